// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter. Bytes are written into a small FIFO and
// serialised onto tx_line as 8N1-style frames (start bit, DATA_BITS data
// bits LSB first, optional even-parity bit, STOP_BITS stop bits). Frames
// are sent back to back with no idle gap while the FIFO holds data.
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN  - when defined, one even-parity bit is inserted
//                        after the data bits. When undefined, no parity
//                        state or logic exists.
//
// Parameters:
//   DATA_BITS     payload bits per frame (5..8)
//   CLKS_PER_BIT  CLK cycles per bit period (>= 2)
//   FIFO_DEPTH    buffered bytes, power of two (2..256)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   write_arg  [8] = write valid, [7:0] = byte to send
//   write_out  ready; a byte is taken on any edge where valid and ready
//   tx_line    registered serial output, idle high
//   busy       high while a frame is on the line or bytes are buffered
//   level      current FIFO occupancy (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [8:0]                    write_arg,
  output logic                          write_out,
  output logic                          tx_line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity over the payload bits actually transmitted.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`endif

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  // Serialiser state
  state_t               state;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_d;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_d;
  logic                 stop_idx;
  logic                 stop_d;
  logic                 shift;
  logic                 line_d;
  logic                 line_busy;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  // Ready depends only on registered occupancy and the reset input, so a
  // write request can never loop back into its own acceptance.
  assign write_out = !RST && (level != LVL_FULL);
  assign push      = write_arg[8] && write_out;
  assign head      = mem[rd_ptr];

  // FIFO control. Pointers are PTR_W bits wide and wrap naturally because
  // FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage carries data only and is not reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= write_arg[DATA_BITS-1:0];
  end

  // Next-state logic. Every bit period is CLKS_PER_BIT cycles: cnt is
  // reloaded to CLKS_PER_BIT-1 on entry to each bit and the bit ends when
  // it reaches zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    stop_d  = stop_idx;
    pop     = 1'b0;
    shift   = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = CNT_LAST;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_LAST;
          bit_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shift = 1'b1;
          cnt_d = CNT_LAST;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
`endif
          end else begin
            bit_d = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          cnt_d   = CNT_LAST;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt == '0) begin
          if (stop_idx == STOP_LAST) begin
            // Chain straight into the next frame when data is waiting,
            // so consecutive frames have no idle gap.
            if (level != '0) begin
              pop     = 1'b1;
              state_d = S_START;
              cnt_d   = CNT_LAST;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
            cnt_d  = CNT_LAST;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the current state; it is registered below, so the line
  // trails the state by one cycle uniformly for every bit.
  always_comb begin
    line_d = 1'b1;
    case (state)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = par_bit;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  // Control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      tx_line   <= 1'b1;
      line_busy <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      stop_idx  <= stop_d;
      tx_line   <= line_d;
      line_busy <= (state != S_IDLE);
    end
  end

  // Payload shift register (data only, not reset)
  always_ff @(posedge CLK) begin
    if (pop) begin
      shreg <= head;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (pop) par_bit <= parity_of(head);
  end
`endif

  // line_busy covers the final registered stop-bit cycle after the FSM has
  // already returned to IDLE, so busy falls the cycle after the line's
  // last stop cycle.
  assign busy = line_busy || (state != S_IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int DB   = 8;
  localparam int CPB  = 4;
  localparam int DEPTH = 4;
  localparam int SB   = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int NB        = 1 + DB + PAR + SB;
  localparam int FRAME_CYC = NB * CPB;

  logic       CLK = 1'b0;
  logic       RST;
  logic [8:0] write_arg;
  logic       write_out;
  logic       tx_line;
  logic       busy;
  logic [2:0] level;

  logic [8:0] write_arg2;
  logic       write_out2;
  logic       tx_line2;
  logic       busy2;
  logic [2:0] level2;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB)
  ) u_dut (
    .CLK(CLK), .RST(RST), .write_arg(write_arg), .write_out(write_out),
    .tx_line(tx_line), .busy(busy), .level(level)
  );

  uart_tx_buffered #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)
  ) u_dut2 (
    .CLK(CLK), .RST(RST), .write_arg(write_arg2), .write_out(write_out2),
    .tx_line(tx_line2), .busy(busy2), .level(level2)
  );

`ifdef UART_TX_PARITY_EN
  logic [8:0] write_arg3;
  logic       write_out3;
  logic       tx_line3;
  logic       busy3;
  logic [2:0] level3;

  uart_tx_buffered #(
    .DATA_BITS(7), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)
  ) u_dut3 (
    .CLK(CLK), .RST(RST), .write_arg(write_arg3), .write_out(write_out3),
    .tx_line(tx_line3), .busy(busy3), .level(level3)
  );
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;
  int         mon_bit = 0;
  logic       mon_active = 1'b0;
  int         max_level = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] frame_of(input logic [7:0] b);
    logic [15:0] f;
    logic        p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) begin
      f[1+i] = b[i];
      p = p ^ b[i];
    end
    if (PAR == 1) f[1+DB] = p;
    return f;
  endfunction

  // Scoreboard monitor: decodes every frame on tx_line and compares each
  // bit, held for CPB cycles, against the next byte in the expected queue.
  task automatic mon_loop();
    logic [15:0] frame;
    logic [7:0]  byte_v;
    int          ccnt;
    logic        bad;
    logic        skip;
    frame = '1; byte_v = '0; ccnt = 0; bad = 1'b0; skip = 1'b0;
    forever begin
      @(negedge CLK);
      if (int'(level) > max_level) max_level = int'(level);
      if (RST === 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx_line === 1'b0) begin
          mon_active = 1'b1;
          mon_bit = 0;
          ccnt = 0;
          bad = 1'b0;
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            tmo("unexpected_frame");
            skip = 1'b1;
          end else begin
            skip = 1'b0;
            byte_v = exp_q.pop_front();
            frame = frame_of(byte_v);
          end
        end
        if (mon_active) begin
          if (tx_line !== frame[mon_bit]) bad = 1'b1;
          ccnt++;
          if (ccnt == CPB) begin
            if (!skip) begin
              checks++;
              if (bad) begin
                errors++;
                $display("FAIL frame_bit: byte %02h bit %0d line differs, required %b",
                         byte_v, mon_bit, frame[mon_bit]);
              end
            end
            ccnt = 0;
            bad = 1'b0;
            mon_bit++;
            if (mon_bit == NB) begin
              mon_active = 1'b0;
              frames_done++;
            end
          end
        end
      end
    end
  endtask

  // Offers one byte, holding valid until ready is seen; records the edge
  // number on which it was accepted.
  task automatic push_byte(input logic [7:0] b, output int acc);
    acc = -1;
    write_arg = {1'b1, b};
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (write_out === 1'b1) begin
        acc = cyc + 1;
        exp_q.push_back(b);
        break;
      end
    end
    @(posedge CLK);
    #1;
    write_arg = '0;
    if (acc < 0) tmo("push_byte");
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (frames_done < target) tmo(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (busy !== 1'b0) tmo(name);
  endtask

  task automatic run_tests();
    int          acc;
    int          base;
    int          f0;
    int          s;
    int          n;
    int          hc;
    int          lows;
    logic [15:0] samp;
    logic        rdy_tab [6];
    rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_write_out_low", write_out, 0);
    chk("rst_tx_line", tx_line, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("release_write_out", write_out, 1);

    // Single byte 0x55
    step();
    base = start_q.size();
    push_byte(8'h55, acc);
    n = 0;
    while (start_q.size() <= base && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (start_q.size() <= base) begin
      tmo("single_start");
    end else begin
      s = start_q[base];
      chk("single_latency", s - acc, 2);
      samp = '0;
      n = 0;
      while (cyc < s + FRAME_CYC - 1 && n < 400) begin
        @(negedge CLK);
        n++;
        if (((cyc - s) % CPB) == 2 && (cyc - s) < FRAME_CYC) samp[(cyc - s) / CPB] = tx_line;
      end
`ifdef UART_TX_PARITY_EN
      chk("single_bits", samp, 16'h04AA);
`else
      chk("single_bits", samp, 16'h02AA);
`endif
      chk("busy_last_stop", busy, 1);
      @(negedge CLK);
      chk("busy_after_stop", busy, 0);
      chk("single_frames", frames_done, 1);
    end

    // Full FIFO: offer 0x01..0x06 on consecutive cycles
    wait_idle(400, "idle_before_full");
    step();
    base = start_q.size();
    f0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      write_arg = {1'b1, 8'(8'h01 + i)};
      @(negedge CLK);
      chk($sformatf("full_ready_%0d", i), write_out, rdy_tab[i]);
      if (write_out === 1'b1) exp_q.push_back(8'(8'h01 + i));
      if (i == 5) chk("full_level", level, 4);
      @(posedge CLK);
      #1;
    end
    write_arg = '0;
    wait_frames(f0 + 5, 6 * FRAME_CYC + 50, "full_frames");
    if (start_q.size() >= base + 5) begin
      for (int k = 1; k < 5; k++)
        chk($sformatf("b2b_gap_%0d", k), start_q[base + k] - start_q[base + k - 1], FRAME_CYC);
    end
    wait_idle(200, "idle_after_full");
    chk("full_sb_empty", exp_q.size(), 0);

    // Pointer wrap: ten paced pushes
    max_level = 0;
    f0 = frames_done;
    step();
    for (int i = 0; i < 10; i++) push_byte(8'(8'hA0 + i), acc);
    wait_frames(f0 + 10, 11 * FRAME_CYC + 50, "wrap_frames");
    chk("wrap_max_level_ok", (max_level <= DEPTH), 1);
    chk("wrap_frame_count", frames_done - f0, 10);
    wait_idle(200, "idle_after_wrap");
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Reset mid-frame with two bytes still queued
    step();
    push_byte(8'h3C, acc);
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    n = 0;
    while (!(mon_active && mon_bit == 4) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!(mon_active && mon_bit == 4)) tmo("reach_data_bit3");
    chk("pre_reset_level", level, 2);
    @(posedge CLK);
    #1 RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk("mid_rst_write_out_low", write_out, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_tx_line", tx_line, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_write_out", write_out, 1);
    base = start_q.size();
    f0 = frames_done;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (tx_line !== 1'b1) lows++;
    end
    chk("mid_rst_line_quiet", lows, 0);
    chk("mid_rst_no_frames", start_q.size() - base, 0);
    chk("mid_rst_frames_done", frames_done - f0, 0);

    // Two stop bits: byte 0x00 then 0xFE back to back
    step();
    write_arg2 = {1'b1, 8'h00};
    @(negedge CLK);
    chk("s2_ready0", write_out2, 1);
    @(posedge CLK);
    #1 write_arg2 = {1'b1, 8'hFE};
    @(negedge CLK);
    chk("s2_ready1", write_out2, 1);
    @(posedge CLK);
    #1 write_arg2 = '0;
    n = 0;
    while (tx_line2 !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (tx_line2 !== 1'b0) tmo("s2_start");
    n = 0;
    while (tx_line2 !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (tx_line2 !== 1'b1) tmo("s2_stop");
    hc = 0;
    while (tx_line2 === 1'b1 && hc < 50) begin
      hc++;
      @(negedge CLK);
    end
    chk("s2_stop_high_run", hc, 8);
    n = 0;
    while (busy2 !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (busy2 !== 1'b0) tmo("s2_idle");
    chk("s2_level", level2, 0);

`ifdef UART_TX_PARITY_EN
    // Parity with 7 data bits: 0x83 sends 1,1,0,0,0,0,0 then parity 0
    step();
    write_arg3 = {1'b1, 8'h83};
    @(negedge CLK);
    chk("par_ready", write_out3, 1);
    @(posedge CLK);
    #1 write_arg3 = '0;
    n = 0;
    while (tx_line3 !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (tx_line3 !== 1'b0) begin
      tmo("par_start");
    end else begin
      s = cyc;
      samp = '0;
      n = 0;
      while (cyc < s + 39 && n < 200) begin
        @(negedge CLK);
        n++;
        if (((cyc - s) % 4) == 2 && (cyc - s) < 40) samp[(cyc - s) / 4] = tx_line3;
      end
      chk("par_bits", samp, 16'h0206);
      chk("par_busy_last", busy3, 1);
      @(negedge CLK);
      chk("par_busy_after", busy3, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    RST = 1'b1;
    write_arg = '0;
    write_arg2 = '0;
`ifdef UART_TX_PARITY_EN
    write_arg3 = '0;
`endif
    fork
      mon_loop();
      run_tests();
    join
  end

endmodule
